// File: rtl/udp_rx_parser_100g.sv
// 100G UDP receive parser: checks Ethernet/IPv4/UDP headers, strips them and streams
// the lane-0 realigned payload with per-packet metadata.
`timescale 1ns/1ps
module udp_rx_parser_100g #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  rx_axis_aclk,
    input  logic                  rx_axis_areset,
    input  logic [47:0]           local_mac,
    input  logic [31:0]           local_ip,
    input  logic [DATA_WIDTH-1:0] cmac_rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] cmac_rx_axis_tkeep,
    input  logic                  cmac_rx_axis_tvalid,
    input  logic                  cmac_rx_axis_tlast,
    output logic                  cmac_rx_axis_tready,
    output logic [DATA_WIDTH-1:0] udp_rx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] udp_rx_axis_tkeep,
    output logic                  udp_rx_axis_tvalid,
    output logic                  udp_rx_axis_tlast,
    output logic                  udp_rx_axis_tuser,
    input  logic                  udp_rx_axis_tready,
    output logic [31:0]           udp_rx_meta_src_ip,
    output logic [15:0]           udp_rx_meta_src_port,
    output logic [15:0]           udp_rx_meta_dst_port,
    output logic [31:0]           stat_rx_pkt_cnt,
    output logic [31:0]           stat_rx_drop_cnt
);

    localparam logic [2:0] StHdr     = 3'd0;
    localparam logic [2:0] StStream  = 3'd1;
    localparam logic [2:0] StDiscard = 3'd2;
    localparam logic [2:0] StDrop    = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;

    function automatic logic [7:0] hbyte(input logic [DATA_WIDTH-1:0] d, input int unsigned n);
        return d[8*n +: 8];
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [6:0] n);
        for (int i = 0; i < KEEP_WIDTH; i++) keep_mask[i] = (7'(i) < n);
    endfunction

    logic [2:0]   state;
    logic [15:0]  rem;
    logic [175:0] resid;      // header-tail / previous-beat bytes 42-63
    logic [4:0]   resid_cnt;
    logic         last_seen;

    logic         can_load, in_fire;
    logic [6:0]   in_cnt;
    logic [47:0]  hdr_dmac;
    logic [15:0]  hdr_udp_len, hdr_rem;
    logic [4:0]   hdr_resid_cnt;
    logic         hdr_ok;
    logic [7:0]   avail;
    logic [6:0]   cap, n_s;
    logic [15:0]  rem_s;
    logic [4:0]   new_resid_cnt, n_d;

    assign can_load = !udp_rx_axis_tvalid || udp_rx_axis_tready;
    assign cmac_rx_axis_tready = can_load && (state == StHdr || state == StStream ||
                                              state == StDiscard || state == StDrop);
    assign in_fire = cmac_rx_axis_tvalid && cmac_rx_axis_tready;
    assign in_cnt  = 7'($countones(cmac_rx_axis_tkeep));

    assign hdr_dmac = {hbyte(cmac_rx_axis_tdata, 0), hbyte(cmac_rx_axis_tdata, 1),
                       hbyte(cmac_rx_axis_tdata, 2), hbyte(cmac_rx_axis_tdata, 3),
                       hbyte(cmac_rx_axis_tdata, 4), hbyte(cmac_rx_axis_tdata, 5)};
    assign hdr_udp_len = {hbyte(cmac_rx_axis_tdata, 38), hbyte(cmac_rx_axis_tdata, 39)};
    assign hdr_rem = hdr_udp_len - 16'd8;
    assign hdr_resid_cnt = (in_cnt >= 7'd42) ? 5'(in_cnt - 7'd42) : 5'd0;

    assign hdr_ok = (in_cnt >= 7'd42)
        && (hdr_dmac == local_mac || hdr_dmac == 48'hFFFF_FFFF_FFFF)
        && ({hbyte(cmac_rx_axis_tdata, 12), hbyte(cmac_rx_axis_tdata, 13)} == 16'h0800)
        && (hbyte(cmac_rx_axis_tdata, 14) == 8'h45)
        && (({hbyte(cmac_rx_axis_tdata, 20), hbyte(cmac_rx_axis_tdata, 21)} & 16'h3FFF) == 16'h0)
        && (hbyte(cmac_rx_axis_tdata, 23) == 8'd17)
        && ({hbyte(cmac_rx_axis_tdata, 30), hbyte(cmac_rx_axis_tdata, 31),
             hbyte(cmac_rx_axis_tdata, 32), hbyte(cmac_rx_axis_tdata, 33)} == local_ip)
        && (hdr_udp_len >= 16'd8);

    // One output beat carries at most 64 of the available residual+input bytes.
    assign avail = {3'b0, resid_cnt} + {1'b0, in_cnt};
    assign cap   = (avail > 8'd64) ? 7'd64 : avail[6:0];
    assign n_s   = (rem < {9'b0, cap}) ? rem[6:0] : cap;
    assign rem_s = rem - {9'b0, n_s};
    assign new_resid_cnt = (in_cnt > 7'd42) ? 5'(in_cnt - 7'd42) : 5'd0;
    assign n_d   = (rem < {11'b0, resid_cnt}) ? rem[4:0] : resid_cnt;

    always_ff @(posedge rx_axis_aclk) begin
        if (rx_axis_areset) begin
            state                <= StHdr;
            rem                  <= '0;
            resid                <= '0;
            resid_cnt            <= '0;
            last_seen            <= 1'b0;
            udp_rx_axis_tdata    <= '0;
            udp_rx_axis_tkeep    <= '0;
            udp_rx_axis_tvalid   <= 1'b0;
            udp_rx_axis_tlast    <= 1'b0;
            udp_rx_axis_tuser    <= 1'b0;
            udp_rx_meta_src_ip   <= '0;
            udp_rx_meta_src_port <= '0;
            udp_rx_meta_dst_port <= '0;
            stat_rx_pkt_cnt      <= '0;
            stat_rx_drop_cnt     <= '0;
        end else begin
            if (udp_rx_axis_tvalid && udp_rx_axis_tready) udp_rx_axis_tvalid <= 1'b0;
            case (state)
                StHdr: if (in_fire) begin
                    if (hdr_ok) begin
                        stat_rx_pkt_cnt      <= stat_rx_pkt_cnt + 32'd1;
                        udp_rx_meta_src_ip   <= {hbyte(cmac_rx_axis_tdata, 26),
                                                 hbyte(cmac_rx_axis_tdata, 27),
                                                 hbyte(cmac_rx_axis_tdata, 28),
                                                 hbyte(cmac_rx_axis_tdata, 29)};
                        udp_rx_meta_src_port <= {hbyte(cmac_rx_axis_tdata, 34),
                                                 hbyte(cmac_rx_axis_tdata, 35)};
                        udp_rx_meta_dst_port <= {hbyte(cmac_rx_axis_tdata, 36),
                                                 hbyte(cmac_rx_axis_tdata, 37)};
                        rem       <= hdr_rem;
                        resid     <= cmac_rx_axis_tdata[DATA_WIDTH-1:336];
                        resid_cnt <= hdr_resid_cnt;
                        last_seen <= cmac_rx_axis_tlast;
                        if (hdr_rem <= {11'b0, hdr_resid_cnt} || cmac_rx_axis_tlast)
                            state <= StDrain;
                        else
                            state <= StStream;
                    end else begin
                        stat_rx_drop_cnt <= stat_rx_drop_cnt + 32'd1;
                        state <= cmac_rx_axis_tlast ? StHdr : StDrop;
                    end
                end
                StStream: if (in_fire) begin
                    udp_rx_axis_tdata  <= {cmac_rx_axis_tdata[335:0], resid};
                    udp_rx_axis_tkeep  <= keep_mask(n_s);
                    udp_rx_axis_tvalid <= 1'b1;
                    udp_rx_axis_tuser  <= 1'b0;
                    udp_rx_axis_tlast  <= 1'b0;
                    rem       <= rem_s;
                    resid     <= cmac_rx_axis_tdata[DATA_WIDTH-1:336];
                    resid_cnt <= new_resid_cnt;
                    if (rem_s == 16'd0) begin
                        udp_rx_axis_tlast <= 1'b1;
                        state <= cmac_rx_axis_tlast ? StHdr : StDiscard;
                    end else if (cmac_rx_axis_tlast) begin
                        if (in_cnt > 7'd42) begin
                            last_seen <= 1'b1;
                            state     <= StDrain;
                        end else begin
                            udp_rx_axis_tlast <= 1'b1;
                            udp_rx_axis_tuser <= 1'b1;
                            state <= StHdr;
                        end
                    end
                end
                StDrain: if (can_load) begin
                    udp_rx_axis_tdata  <= {336'b0, resid};
                    udp_rx_axis_tkeep  <= keep_mask({2'b0, n_d});
                    udp_rx_axis_tvalid <= 1'b1;
                    udp_rx_axis_tlast  <= 1'b1;
                    udp_rx_axis_tuser  <= (rem > {11'b0, resid_cnt});
                    rem   <= rem - {11'b0, n_d};
                    state <= last_seen ? StHdr : StDiscard;
                end
                StDiscard, StDrop: if (in_fire && cmac_rx_axis_tlast) state <= StHdr;
                default: state <= StHdr;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_parser_100g.sv
// Scoreboard bench for udp_rx_parser_100g: directed frames, expected payload beats queued at
// stimulus time and checked by an independent output monitor.
`timescale 1ns/1ps
module tb_udp_rx_parser_100g;

    typedef logic [7:0] u8_t;
    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic         user;
        logic [63:0]  meta;
    } exp_t;

    localparam logic [47:0] LMAC = 48'h02_11_22_33_44_55;
    localparam logic [31:0] LIP  = 32'hC0A8_0102;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] in_data = '0;
    logic [63:0]  in_keep = '0;
    logic         in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic         out_valid, out_last, out_user;
    logic         out_ready = 1'b1;
    logic [31:0]  m_sip, pkt_cnt, drop_cnt;
    logic [15:0]  m_sp, m_dp;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   exp_pkt = 0, exp_drop = 0;
    logic toggle_en = 1'b0;

    always #5 clk = ~clk;

    udp_rx_parser_100g dut (
        .rx_axis_aclk         (clk),
        .rx_axis_areset       (rst),
        .local_mac            (LMAC),
        .local_ip             (LIP),
        .cmac_rx_axis_tdata   (in_data),
        .cmac_rx_axis_tkeep   (in_keep),
        .cmac_rx_axis_tvalid  (in_valid),
        .cmac_rx_axis_tlast   (in_last),
        .cmac_rx_axis_tready  (in_ready),
        .udp_rx_axis_tdata    (out_data),
        .udp_rx_axis_tkeep    (out_keep),
        .udp_rx_axis_tvalid   (out_valid),
        .udp_rx_axis_tlast    (out_last),
        .udp_rx_axis_tuser    (out_user),
        .udp_rx_axis_tready   (out_ready),
        .udp_rx_meta_src_ip   (m_sip),
        .udp_rx_meta_src_port (m_sp),
        .udp_rx_meta_dst_port (m_dp),
        .stat_rx_pkt_cnt      (pkt_cnt),
        .stat_rx_drop_cnt     (drop_cnt)
    );

    function automatic void chk(string name, logic [511:0] got, logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endfunction

    // Frame: dst MAC, src MAC, ethertype, IPv4 header, UDP header, payload, pad to 60, cut.
    function automatic void build(output u8_t f[$], input logic [47:0] dmac,
                                  input logic [15:0] etype, input logic [7:0] proto,
                                  input logic [31:0] dip, input int udp_len, input int pay_len,
                                  input int cut, input logic [7:0] seed);
        logic [15:0] tot, ul, sp;
        tot = 16'(20 + udp_len);
        ul  = 16'(udp_len);
        sp  = 16'h1000 + {8'h0, seed};
        f = {};
        for (int i = 5; i >= 0; i--) f.push_back(dmac[8*i +: 8]);
        f.push_back(8'h02); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h01);
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(8'h45); f.push_back(8'h00); f.push_back(tot[15:8]); f.push_back(tot[7:0]);
        f.push_back(8'h12); f.push_back(8'h34); f.push_back(8'h40); f.push_back(8'h00);
        f.push_back(8'd64); f.push_back(proto); f.push_back(8'h00); f.push_back(8'h00);
        f.push_back(8'h0A); f.push_back(8'h00); f.push_back(8'h00); f.push_back(seed);
        for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
        f.push_back(sp[15:8]); f.push_back(sp[7:0]); f.push_back(8'hAB); f.push_back(8'hCD);
        f.push_back(ul[15:8]); f.push_back(ul[7:0]); f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < pay_len; i++) f.push_back(8'(seed + 8'(i)));
        while (f.size() < 60) f.push_back(8'h00);
        if (cut > 0) while (f.size() > cut) void'(f.pop_back());
    endfunction

    // Reference: payload = min(udp_len-8, bytes after header), split into 64-byte beats.
    function automatic void expect_frame(input u8_t f[$]);
        int rem, avl, n, nb;
        exp_t e;
        rem = int'({f[38], f[39]}) - 8;
        avl = f.size() - 42;
        n   = (rem < avl) ? rem : avl;
        nb  = (n == 0) ? 1 : (n + 63) / 64;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            e.keep = '0;
            for (int i = 0; i < 64; i++) begin
                if (b * 64 + i < n) begin
                    e.data[8*i +: 8] = f[42 + b * 64 + i];
                    e.keep[i] = 1'b1;
                end
            end
            e.last = (b == nb - 1);
            e.user = e.last && (rem > avl);
            e.meta = {f[26], f[27], f[28], f[29], f[34], f[35], f[36], f[37]};
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_frame(input u8_t f[$], input int max_beats);
        int t;
        for (int b = 0; b * 64 < f.size() && b < max_beats; b++) begin
            in_data = '0;
            in_keep = '0;
            for (int i = 0; i < 64; i++) begin
                if (b * 64 + i < f.size()) begin
                    in_data[8*i +: 8] = f[b * 64 + i];
                    in_keep[i] = 1'b1;
                end
            end
            in_last  = (b * 64 + 64 >= f.size());
            in_valid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: got tready=0 want tready=1");
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_pkt"}, pkt_cnt, exp_pkt);
        chk({name, "_drop"}, drop_cnt, exp_drop);
    endtask

    // Output monitor: scoreboard pop on handshake, stability check while stalled.
    initial begin
        exp_t e;
        logic [511:0] m;
        logic         held_v;
        logic [579:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v)
                    chk("stall_hold", {out_valid, out_last, out_user, out_keep, out_data},
                        {1'b1, held});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got keep %0h want no beat", out_keep);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < 64; i++) m[8*i +: 8] = {8{e.keep[i]}};
                        chk("data", out_data & m, e.data);
                        chk("keep", out_keep, e.keep);
                        chk("last_user", {out_last, out_user}, {e.last, e.user});
                        chk("meta", {m_sip, m_sp, m_dp}, e.meta);
                    end
                end
                held_v = out_valid && !out_ready;
                held   = {out_last, out_user, out_keep, out_data};
            end
        end
    end

    // Downstream ready pattern 1,0,0,1 when enabled.
    initial begin
        int idx;
        logic [3:0] pat;
        idx = 0;
        pat = 4'b1001;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                out_ready = pat[idx];
                idx = (idx + 1) % 4;
            end
        end
    end

    initial begin
        u8_t f[$];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {out_valid, out_last, out_user, out_keep}, '0);
        chk("rst_data", out_data, '0);
        chk("rst_meta", {m_sip, m_sp, m_dp}, '0);
        chk_counts("rst");
        rst = 1'b0;

        // 22-byte payload in a single 64-byte beat: keep 0x3FFFFF
        build(f, LMAC, 16'h0800, 8'd17, LIP, 30, 22, 0, 8'h01);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_single");
        chk_counts("single");

        // 100-byte payload, 142-byte frame: beats of 64 B then 36 B
        build(f, LMAC, 16'h0800, 8'd17, LIP, 108, 100, 0, 8'h20);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_multi");

        // 4-byte payload padded to 60 bytes: keep 0xF, padding trimmed
        build(f, LMAC, 16'h0800, 8'd17, LIP, 12, 4, 0, 8'h40);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_min");
        chk_counts("min");

        // Rejects: IPv6 ethertype, wrong dst IP (multi-beat), TCP
        build(f, LMAC, 16'h86DD, 8'd17, LIP, 30, 22, 0, 8'h50);
        send_frame(f, 99); exp_drop++;
        build(f, LMAC, 16'h0800, 8'd17, 32'hC0A8_0109, 108, 100, 0, 8'h51);
        send_frame(f, 99); exp_drop++;
        build(f, LMAC, 16'h0800, 8'd6, LIP, 30, 22, 0, 8'h52);
        send_frame(f, 99); exp_drop++;
        build(f, 48'hFFFF_FFFF_FFFF, 16'h0800, 8'd17, LIP, 50, 42, 0, 8'h60);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_after_drop");
        chk_counts("drop");

        // udp_len 200 but only 128 bytes: 86 bytes out, tuser on last
        build(f, LMAC, 16'h0800, 8'd17, LIP, 200, 192, 128, 8'h70);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_trunc");
        chk_counts("trunc");

        // 3-beat frame with downstream stalls
        build(f, LMAC, 16'h0800, 8'd17, LIP, 158, 150, 0, 8'h80);
        expect_frame(f); exp_pkt++;
        toggle_en = 1'b1;
        send_frame(f, 99);
        wait_empty("drain_stall");
        toggle_en = 1'b0;
        out_ready = 1'b1;
        chk_counts("stall");

        // Reset mid-packet with an output beat stuck in the register
        out_ready = 1'b0;
        send_frame(f, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("stuck_valid", out_valid, 1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out", {out_valid, out_last, out_user, out_keep}, '0);
        chk("mid_rst_meta", {m_sip, m_sp, m_dp}, '0);
        exp_pkt = 0;
        exp_drop = 0;
        chk_counts("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        build(f, LMAC, 16'h0800, 8'd17, LIP, 30, 22, 0, 8'h90);
        expect_frame(f); exp_pkt++;
        send_frame(f, 99);
        wait_empty("drain_post_rst");
        chk_counts("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
